// File: rtl/msrv32_wb_port_arbiter_pkg.sv
// Shared definitions for the integer-file writeback port arbiter.
package msrv32_wb_pkg;

    // Default datapath widths of the integer register file write port.
    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    // Register x0 is hard-wired to zero; writes to it never reach the file.
    localparam int X0_ADDR = 0;

    // Width of the aux starvation counter (limit range 1..15).
    localparam int STARVE_W = 4;

    // Which requester currently wins a simultaneous request.
    typedef enum logic {
        PIPE_PRI = 1'b0,
        AUX_PRI  = 1'b1
    } arb_state_e;

endpackage : msrv32_wb_pkg

// File: rtl/msrv32_wb_port_arbiter_if.sv
// Writeback-port bundle: pipeline and aux requests, grants, and the
// registered integer-file write port.
interface msrv32_wb_port_arbiter_if #(
    parameter int XLEN = msrv32_wb_pkg::XLEN_DEF,
    parameter int RA_W = msrv32_wb_pkg::RA_W_DEF
);

    // Pipeline writeback requester
    logic                          flush_in;
    logic                          pipe_wr_req_in;
    logic [RA_W-1:0]               pipe_rd_addr_in;
    logic [XLEN-1:0]               pipe_rd_data_in;
    logic                          pipe_wr_gnt_out;
    logic                          pipe_stall_out;

    // Long-latency auxiliary requester
    logic                          aux_wr_req_in;
    logic [RA_W-1:0]               aux_rd_addr_in;
    logic [XLEN-1:0]               aux_rd_data_in;
    logic                          aux_wr_gnt_out;

    // Integer register file write port
    logic                          wr_en_integer_file_out;
    logic [RA_W-1:0]               rd_addr_out;
    logic [XLEN-1:0]               rd_data_out;
    logic [msrv32_wb_pkg::STARVE_W-1:0] starve_cnt_out;

    // Arbiter side
    modport slave (
        input  flush_in, pipe_wr_req_in, pipe_rd_addr_in, pipe_rd_data_in,
        input  aux_wr_req_in, aux_rd_addr_in, aux_rd_data_in,
        output pipe_wr_gnt_out, pipe_stall_out, aux_wr_gnt_out,
        output wr_en_integer_file_out, rd_addr_out, rd_data_out, starve_cnt_out
    );

    // Requester / register-file side
    modport master (
        output flush_in, pipe_wr_req_in, pipe_rd_addr_in, pipe_rd_data_in,
        output aux_wr_req_in, aux_rd_addr_in, aux_rd_data_in,
        input  pipe_wr_gnt_out, pipe_stall_out, aux_wr_gnt_out,
        input  wr_en_integer_file_out, rd_addr_out, rd_data_out, starve_cnt_out
    );

endinterface : msrv32_wb_port_arbiter_if

// File: rtl/msrv32_wb_port_arbiter.sv
// Arbitrates the single integer-register-file write port between the
// in-order writeback stage and the long-latency aux unit. The pipeline
// normally wins; an aux request denied STARVE_LIMIT times in a row gets
// one cycle of priority. Flush squashes only the pipeline request.
module msrv32_wb_port_arbiter
    import msrv32_wb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int RA_W         = RA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    msrv32_wb_port_arbiter_if.slave    bus
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
    localparam logic [RA_W-1:0]     X0    = RA_W'(X0_ADDR);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                preq;
    logic                pipe_gnt, aux_gnt;
    logic [RA_W-1:0]     win_addr;
    logic [XLEN-1:0]     win_data;
    logic                wr_en_q;
    logic [RA_W-1:0]     addr_q;
    logic [XLEN-1:0]     data_q;

    // Grant decision: priority follows the FSM state; nothing is granted in reset.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        preq     = bus.pipe_wr_req_in & ~bus.flush_in;
        pipe_gnt = 1'b0;
        aux_gnt  = 1'b0;
        if (!rst_in) begin
            unique case (state_q)
                PIPE_PRI: begin
                    if (preq)                   pipe_gnt = 1'b1;
                    else if (bus.aux_wr_req_in) aux_gnt  = 1'b1;
                end
                AUX_PRI: begin
                    if (bus.aux_wr_req_in) aux_gnt  = 1'b1;
                    else if (preq)         pipe_gnt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next starvation count and priority state.
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;

        // Aux granted or no longer waiting: nothing is starving.
        if (aux_gnt || !bus.aux_wr_req_in) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        unique case (state_q)
            PIPE_PRI: if (starve_d == LIMIT) state_d = AUX_PRI;
            AUX_PRI:  if (aux_gnt || !bus.aux_wr_req_in) state_d = PIPE_PRI;
            default:  state_d = PIPE_PRI;
        endcase
    end

    // Priority FSM and starvation counter registers.
    always_ff @(posedge clk_in) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst_in) begin
            state_q  <= PIPE_PRI;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Winner's address/data; only meaningful when some grant is active.
    assign win_addr = aux_gnt ? bus.aux_rd_addr_in : bus.pipe_rd_addr_in;
    assign win_data = aux_gnt ? bus.aux_rd_data_in : bus.pipe_rd_data_in;

    // Output register: load the winner, suppress the enable for x0, hold otherwise.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (pipe_gnt || aux_gnt) begin
            wr_en_q <= (win_addr != X0);
            addr_q  <= win_addr;
            data_q  <= win_data;
        end else begin
            wr_en_q <= 1'b0;
        end
    end

    assign bus.pipe_wr_gnt_out = pipe_gnt;
    assign bus.aux_wr_gnt_out  = aux_gnt;
    assign bus.pipe_stall_out  = preq & ~pipe_gnt;

    // A write registered just before reset asserts is presented during the
    // reset cycle; masking with rst_in keeps it from ever reaching the file.
    assign bus.wr_en_integer_file_out = wr_en_q & ~rst_in;
    assign bus.rd_addr_out            = addr_q;
    assign bus.rd_data_out            = data_q;
    assign bus.starve_cnt_out         = starve_q;

endmodule : msrv32_wb_port_arbiter

// File: tb/tb_msrv32_wb_port_arbiter.sv
// Directed bench for the writeback port arbiter: expected file writes are
// queued when a grant is expected and compared one cycle later.
module tb_msrv32_wb_port_arbiter;
    import msrv32_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    msrv32_wb_port_arbiter_if #(.XLEN(32), .RA_W(5)) bus ();

    msrv32_wb_port_arbiter #(
        .XLEN        (32),
        .RA_W        (5),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [4:0]  hold_addr = '0;
    logic [31:0] hold_data = '0;
    logic        saw_x4 = 1'b0;

    // Watch for any write to x4 reaching the file.
    always @(negedge clk) begin
        if (bus.wr_en_integer_file_out === 1'b1 && bus.rd_addr_out === 5'd4)
            saw_x4 <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One arbitration cycle: check grants/stall, queue the expected write,
    // clock, then compare the registered port against the scoreboard.
    task automatic step(input string tag, input logic e_pg, input logic e_ag, input logic e_stall);
        wr_t exp;
        #1;
        check({tag, "/pipe_gnt"}, 32'(bus.pipe_wr_gnt_out), 32'(e_pg));
        check({tag, "/aux_gnt"},  32'(bus.aux_wr_gnt_out),  32'(e_ag));
        check({tag, "/stall"},    32'(bus.pipe_stall_out),  32'(e_stall));
        if (e_pg)
            sb.push_back('{bus.pipe_rd_addr_in != 5'd0, bus.pipe_rd_addr_in, bus.pipe_rd_data_in});
        else if (e_ag)
            sb.push_back('{bus.aux_rd_addr_in != 5'd0, bus.aux_rd_addr_in, bus.aux_rd_data_in});
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            exp       = sb.pop_front();
            hold_addr = exp.addr;
            hold_data = exp.data;
        end else begin
            exp = '{1'b0, hold_addr, hold_data};
        end
        check({tag, "/wr_en"}, 32'(bus.wr_en_integer_file_out), 32'(exp.en));
        check({tag, "/addr"},  32'(bus.rd_addr_out),            32'(exp.addr));
        check({tag, "/data"},  bus.rd_data_out,                 exp.data);
    endtask

    initial begin
        // Reset with both requesters active.
        bus.flush_in        = 1'b0;
        bus.pipe_wr_req_in  = 1'b1;
        bus.pipe_rd_addr_in = 5'd2;
        bus.pipe_rd_data_in = 32'h1111_1111;
        bus.aux_wr_req_in   = 1'b1;
        bus.aux_rd_addr_in  = 5'd3;
        bus.aux_rd_data_in  = 32'h2222_2222;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst/pipe_gnt", 32'(bus.pipe_wr_gnt_out), 32'd0);
        check("rst/aux_gnt",  32'(bus.aux_wr_gnt_out),  32'd0);
        check("rst/wr_en",    32'(bus.wr_en_integer_file_out), 32'd0);
        check("rst/addr",     32'(bus.rd_addr_out), 32'd0);
        check("rst/data",     bus.rd_data_out, 32'd0);
        check("rst/starve",   32'(bus.starve_cnt_out), 32'd0);
        rst = 1'b0;
        bus.pipe_wr_req_in = 1'b0;
        bus.aux_wr_req_in  = 1'b0;

        // Pipeline-only write, then idle: enable drops, addr/data hold.
        bus.pipe_wr_req_in  = 1'b1;
        bus.pipe_rd_addr_in = 5'd5;
        bus.pipe_rd_data_in = 32'hDEAD_BEEF;
        step("pipe_only", 1'b1, 1'b0, 1'b0);
        bus.pipe_wr_req_in = 1'b0;
        step("pipe_idle", 1'b0, 1'b0, 1'b0);

        // Contention: pipe wins four times, then aux is forced through.
        bus.pipe_wr_req_in  = 1'b1;
        bus.pipe_rd_addr_in = 5'd3;
        bus.aux_wr_req_in   = 1'b1;
        bus.aux_rd_addr_in  = 5'd7;
        bus.aux_rd_data_in  = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            bus.pipe_rd_data_in = 32'hA0 + 32'(i);
            step("cont_pipe", 1'b1, 1'b0, 1'b0);
            check("cont_pipe/starve", 32'(bus.starve_cnt_out), 32'(i + 1));
        end
        step("cont_aux", 1'b0, 1'b1, 1'b1);
        check("cont_aux/starve", 32'(bus.starve_cnt_out), 32'd0);
        // A fresh aux request loses again: pipe has priority back.
        bus.aux_rd_addr_in = 5'd8;
        bus.aux_rd_data_in = 32'h0000_0088;
        bus.pipe_rd_data_in = 32'h0000_00B0;
        step("cont_pipe_back", 1'b1, 1'b0, 1'b0);
        check("cont_pipe_back/starve", 32'(bus.starve_cnt_out), 32'd1);
        // Aux abandons its request: counter clears, nothing is written.
        bus.pipe_wr_req_in = 1'b0;
        bus.aux_wr_req_in  = 1'b0;
        step("aux_drop", 1'b0, 1'b0, 1'b0);
        check("aux_drop/starve", 32'(bus.starve_cnt_out), 32'd0);

        // Flush squashes the pipe request: no grant, no stall, no write.
        bus.flush_in        = 1'b1;
        bus.pipe_wr_req_in  = 1'b1;
        bus.pipe_rd_addr_in = 5'd6;
        bus.pipe_rd_data_in = 32'h0000_0066;
        step("flush_only", 1'b0, 1'b0, 1'b0);
        // Flush with aux pending: aux goes through.
        bus.aux_wr_req_in  = 1'b1;
        bus.aux_rd_addr_in = 5'd9;
        bus.aux_rd_data_in = 32'h0000_0099;
        step("flush_aux", 1'b0, 1'b1, 1'b0);
        bus.flush_in       = 1'b0;
        bus.pipe_wr_req_in = 1'b0;
        bus.aux_wr_req_in  = 1'b0;

        // Write to x0: granted, enable suppressed, addr/data still loaded.
        bus.aux_wr_req_in  = 1'b1;
        bus.aux_rd_addr_in = 5'd0;
        bus.aux_rd_data_in = 32'hFFFF_FFFF;
        step("x0", 1'b1 == 1'b0, 1'b1, 1'b0);
        bus.aux_wr_req_in = 1'b0;

        // Reset right after a granted pipe write to x4: the write is dropped.
        bus.pipe_wr_req_in  = 1'b1;
        bus.pipe_rd_addr_in = 5'd4;
        bus.pipe_rd_data_in = 32'h0000_0044;
        #1;
        check("mid_rst/pipe_gnt", 32'(bus.pipe_wr_gnt_out), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.pipe_wr_req_in = 1'b0;
        #1;
        check("mid_rst/wr_en_masked", 32'(bus.wr_en_integer_file_out), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst/wr_en",  32'(bus.wr_en_integer_file_out), 32'd0);
        check("mid_rst/addr",   32'(bus.rd_addr_out), 32'd0);
        check("mid_rst/data",   bus.rd_data_out, 32'd0);
        check("mid_rst/starve", 32'(bus.starve_cnt_out), 32'd0);
        rst = 1'b0;
        hold_addr = '0;
        hold_data = '0;
        // Priority is back to the pipeline after reset.
        bus.pipe_wr_req_in  = 1'b1;
        bus.pipe_rd_addr_in = 5'd10;
        bus.pipe_rd_data_in = 32'h0000_00AA;
        bus.aux_wr_req_in   = 1'b1;
        bus.aux_rd_addr_in  = 5'd11;
        bus.aux_rd_data_in  = 32'h0000_00BB;
        step("post_rst", 1'b1, 1'b0, 1'b0);
        check("post_rst/starve", 32'(bus.starve_cnt_out), 32'd1);
        bus.pipe_wr_req_in = 1'b0;
        bus.aux_wr_req_in  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("no_x4_write", 32'(saw_x4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_msrv32_wb_port_arbiter
